// File: rtl/pcie_ss_axis_pkg.sv
// rtl/pcie_ss_axis_pkg.sv - PCIe SS sideband types shared by the FLR response generator
package pcie_ss_axis_pkg;

    // Identifies one PCIe function: physical function, virtual function, VF
    // valid flag and the slot it lives behind.
    typedef struct packed {
        logic [4:0]  slot;
        logic        vf_active;
        logic [10:0] vf;
        logic [2:0]  pf;
    } t_flr_func;

    // FLR request/response sideband beat (no tready on this interface).
    typedef struct packed {
        logic      tvalid;
        logic      tlast;
        t_flr_func tdata;
    } t_axis_pcie_flr;

    localparam int T_AXIS_PCIE_FLR_WIDTH = $bits(t_axis_pcie_flr);
    localparam int T_FLR_FUNC_WIDTH      = $bits(t_flr_func);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        RSP    = 2'd2
    } t_flr_rsp_state;

endpackage

// File: rtl/pcie_flr_req_fifo.sv
// rtl/pcie_flr_req_fifo.sv - first-word-fall-through FIFO holding pending FLR requests
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_wdata write strobe and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   i_pop           consume the head entry (ignored when empty)
//   o_rdata         head entry, valid whenever o_empty is low
//   o_full, o_empty occupancy flags
module pcie_flr_req_fifo
    import pcie_ss_axis_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = T_FLR_FUNC_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/pcie_flr_rsp_gen.sv
// rtl/pcie_flr_rsp_gen.sv - FLR request queue, per-function reset sequencing and FLR-complete response
//
// Optional feature macro: PCIE_FLR_RSP_TIMEOUT_EN (ack timeout, err_timeout).
//
// Ports:
//   i_clk, i_rst_n     sideband clock, asynchronous active-low reset
//   i_flr_req_if       FLR request beats from the PCIe SS (tvalid pulse per request)
//   o_flr_rsp_if       FLR-complete beat back to the PCIe SS (one-cycle tvalid)
//   o_rst_req          reset request for the function on o_rst_func
//   o_rst_func         function under reset, stable while o_rst_req is high
//   i_rst_ack          level acknowledge from the port reset controller
//   o_busy             requests pending or a reset sequence in progress
//   o_err_overflow     sticky, a request was dropped on a full queue
//   o_err_timeout      sticky, ack never arrived (0 unless the timeout is built in)
module pcie_flr_rsp_gen
    import pcie_ss_axis_pkg::*;
#(
    parameter int REQ_DEPTH       = 4,
    parameter int MIN_HOLD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  t_axis_pcie_flr i_flr_req_if,
    output t_axis_pcie_flr o_flr_rsp_if,
    output logic           o_rst_req,
    output t_flr_func      o_rst_func,
    input  logic           i_rst_ack,
    output logic           o_busy,
    output logic           o_err_overflow,
    output logic           o_err_timeout
);

    localparam int HW = $clog2(MIN_HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MIN_HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_EXIT = HW'(MIN_HOLD_CYCLES - 1);

    if (REQ_DEPTH < 2 || (REQ_DEPTH & (REQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("REQ_DEPTH must be a power of 2 and at least 2");
    end
    if (MIN_HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("MIN_HOLD_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    t_flr_rsp_state              r_state;
    t_flr_rsp_state              w_state_nxt;
    t_flr_func                   r_rst_func;
    logic [HW-1:0]               r_hold_cnt;
    logic                        r_err_overflow;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [T_FLR_FUNC_WIDTH-1:0] w_fifo_rdata;
    logic                        w_ack_done;
    logic                        w_to_hit;

    pcie_flr_req_fifo #(
        .DEPTH (REQ_DEPTH),
        .WIDTH (T_FLR_FUNC_WIDTH)
    ) u_req_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_flr_req_if.tvalid),
        .i_wdata (i_flr_req_if.tdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Normal exit: downstream quiesced and the function has been held long enough.
    assign w_ack_done = i_rst_ack && (r_hold_cnt >= HOLD_EXIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        o_rst_req    = 1'b0;
        o_flr_rsp_if = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                o_rst_req = 1'b1;
                if (w_ack_done || w_to_hit) w_state_nxt = RSP;
            end
            RSP: begin
                o_flr_rsp_if.tvalid = 1'b1;
                o_flr_rsp_if.tlast  = 1'b1;
                o_flr_rsp_if.tdata  = r_rst_func;
                w_state_nxt         = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_func     <= '0;
            r_hold_cnt     <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rst_func <= t_flr_func'(w_fifo_rdata);
                r_hold_cnt <= '0;
            end else if (r_state == ASSERT && r_hold_cnt != HOLD_SAT) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            // A full queue still takes a request when the head leaves this cycle.
            if (i_flr_req_if.tvalid && w_full && !w_pop) r_err_overflow <= 1'b1;
        end
    end

`ifdef PCIE_FLR_RSP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_err_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_pop) begin
                r_to_cnt <= '0;
            end else if (r_state == ASSERT && r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            // Flag only when the timeout, not the ack, forced the response.
            if (r_state == ASSERT && w_to_hit && !w_ack_done) r_err_timeout <= 1'b1;
        end
    end

    assign w_to_hit      = (r_to_cnt == TO_LAST);
    assign o_err_timeout = r_err_timeout;
`else
    assign w_to_hit      = 1'b0;
    assign o_err_timeout = 1'b0;
`endif

    assign o_rst_func     = r_rst_func;
    assign o_busy         = !w_empty || (r_state != IDLE);
    assign o_err_overflow = r_err_overflow;

endmodule
